// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : midi_pkg
// Description : Shared definitions for the MIDI receive FIFO block:
//               register offsets, STATUS/CTRL bit positions, receiver FSM
//               state encoding and the STATUS count saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

  // Register select values (reg_sel)
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS register bit positions; bits [2:0] carry the saturated count
  localparam int STAT_AVAIL   = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_OVERRUN = 5;
  localparam int STAT_FRAMING = 4;
  localparam int STAT_IRQ_EN  = 3;

  // CTRL register bit positions
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 6;
  localparam int CTRL_CLEAR   = 7;

  // Serial receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // The STATUS register only has three bits of count; a full 8-deep FIFO
  // reports 7 there and relies on the FULL bit to disambiguate.
  function automatic logic [2:0] sat_count3(input int unsigned n);
    return (n > 32'd7) ? 3'd7 : 3'(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Circular byte buffer for the MIDI receiver.
//               A push while full is dropped unless a pop happens on the
//               same edge, in which case both take effect. A pop while
//               empty is ignored. Flush returns pointers and count to zero.
//               Storage is not reset; an empty FIFO masks its contents.
// Ports       : clock  - system clock
//               reset  - asynchronous active-low reset
//               push   - write wdata at the tail
//               pop    - advance the head
//               flush  - discard all contents (highest priority)
//               wdata  - byte to push
//               rdata  - byte at the head (meaningless when empty)
//               full   - count == DEPTH
//               empty  - count == 0
//               count  - number of bytes held
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop on the same edge frees the slot the push needs, so a full FIFO
  // still accepts the new byte in that case.
  assign do_pop  = pop  & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array without reset
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : midi_rx_fifo
// Description : MIDI serial receiver (8N1, LSB first) with a receive FIFO
//               and a two-register CPU interface.
//                 DATA   (reg_sel=0) read : head byte, pops once per read
//                                   write : ignored
//                 STATUS (reg_sel=1) read : {avail, full, overrun,
//                                            framing_err, irq_en, count[2:0]}
//                 CTRL   (reg_sel=1) write: bit0 irq_en, bit6 flush,
//                                           bit7 clear error flags
// Ports       : clock    - system clock
//               reset    - asynchronous active-low reset
//               rxd_in   - asynchronous serial input, idle high
//               cs       - register select strobe
//               r_w      - 1 = read, 0 = write
//               reg_sel  - 0 = DATA, 1 = STATUS/CTRL
//               data_in  - CPU write data
//               data_out - CPU read data, 0x00 unless cs & r_w
//               irq_n    - active-low interrupt, registered
// Revision    : 1.0 - initial release
// ============================================================================
module midi_rx_fifo
  import midi_pkg::*;
#(
  parameter int BIT_CLKS   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd_in,
  input  logic       cs,
  input  logic       r_w,
  input  logic       reg_sel,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq_n
);

  localparam int CNT_W = $clog2(BIT_CLKS + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CLKS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // --------------------------------------------------------------------------
  logic sync_meta;
  logic sync_rx;
  logic rx_prev;

  // All three flops reset high so leaving reset never looks like a start edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      sync_rx   <= 1'b1;
      rx_prev   <= 1'b1;
    end else begin
      sync_meta <= rxd_in;
      sync_rx   <= sync_meta;
      rx_prev   <= sync_rx;
    end
  end

  logic start_edge;
  assign start_edge = rx_prev & ~sync_rx;

  // --------------------------------------------------------------------------
  // Serial receiver
  // --------------------------------------------------------------------------
  rx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             push_req;
  logic             frame_err_pulse;

  // Only a true 1->0 transition leaves IDLE, so a line held low after a
  // framing error (a break) cannot restart the receiver and report again.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= RX_IDLE;
      bit_cnt         <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      push_req        <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      push_req        <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (start_edge) begin
            state   <= RX_START;
            bit_cnt <= HALF_LOAD;
          end
        end

        RX_START: begin
          // Re-check the line in mid start bit to reject short glitches
          if (bit_cnt == '0) begin
            if (!sync_rx) begin
              state   <= RX_DATA;
              bit_cnt <= FULL_LOAD;
              bit_idx <= '0;
            end else begin
              state   <= RX_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end

        RX_DATA: begin
          if (bit_cnt == '0) begin
            shift_reg <= {sync_rx, shift_reg[7:1]};
            bit_cnt   <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state   <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end

        RX_STOP: begin
          if (bit_cnt == '0) begin
            if (sync_rx) begin
              push_req        <= 1'b1;
            end else begin
              frame_err_pulse <= 1'b1;
            end
            state <= RX_IDLE;
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register interface decode
  // --------------------------------------------------------------------------
  logic data_rd;
  logic data_rd_prev;
  logic ctrl_wr;
  logic pop;
  logic flush;
  logic clear_flags;

  assign data_rd     = cs & r_w & (reg_sel == REG_DATA);
  assign ctrl_wr     = cs & ~r_w & (reg_sel == REG_STATUS);
  // A read held for several cycles consumes exactly one byte
  assign pop         = data_rd & ~data_rd_prev;
  assign flush       = ctrl_wr & data_in[CTRL_FLUSH];
  assign clear_flags = ctrl_wr & data_in[CTRL_CLEAR];

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^data_in[5:1];

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0]     fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .wdata (shift_reg),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // --------------------------------------------------------------------------
  // Flags, interrupt enable and interrupt output
  // --------------------------------------------------------------------------
  logic overrun;
  logic framing_err;
  logic irq_en;
  logic avail;
  logic overrun_set;

  assign avail = ~fifo_empty;
  // A pop on the same edge makes room, so that push is not an overrun
  assign overrun_set = push_req & fifo_full & ~pop & ~flush;

  // A new error on the same edge as a clear wins, so no event is lost
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_rd_prev <= 1'b0;
      overrun      <= 1'b0;
      framing_err  <= 1'b0;
      irq_en       <= 1'b0;
      irq_n        <= 1'b1;
    end else begin
      data_rd_prev <= data_rd;
      if (ctrl_wr) begin
        irq_en <= data_in[CTRL_IRQ_EN];
      end
      overrun     <= (overrun & ~clear_flags) | overrun_set;
      framing_err <= (framing_err & ~clear_flags) | frame_err_pulse;
      irq_n       <= ~(irq_en & (avail | overrun | framing_err));
    end
  end

  // --------------------------------------------------------------------------
  // Read data mux
  // --------------------------------------------------------------------------
  logic [7:0] status;

  always_comb begin
    status               = '0;
    status[STAT_AVAIL]   = avail;
    status[STAT_FULL]    = fifo_full;
    status[STAT_OVERRUN] = overrun;
    status[STAT_FRAMING] = framing_err;
    status[STAT_IRQ_EN]  = irq_en;
    status[2:0]          = sat_count3(32'(fifo_count));
  end

  always_comb begin
    data_out = 8'h00;
    if (cs && r_w) begin
      if (reg_sel == REG_STATUS) begin
        data_out = status;
      end else if (!fifo_empty) begin
        data_out = fifo_rdata;
      end
    end
  end

endmodule
`default_nettype wire
